// File: rtl/aes_tiled_pkg.sv
// Shared encodings for the tiled AES request arbiter: operation codes and FSM states.
package aes_tiled_pkg;

  typedef enum logic [1:0] {
    OpSb      = 2'b00,
    OpSbsr    = 2'b01,
    OpMix     = 2'b10,
    OpIllegal = 2'b11
  } aes_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } aes_state_e;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: combinational grant, priority pointer advances on a grant.
module aes_rr_arb2 (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic [1:0] req_valid,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr_q names the requester that wins the next tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aes_tiled_arb.sv
// Arbitrates two requesters onto one tiled AES unit, one op outstanding at a time.
module aes_tiled_arb
  import aes_tiled_pkg::*;
#(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic        req0_dec,
  input  logic        req0_hi,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_rd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic        req1_dec,
  input  logic        req1_hi,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_rd,
  output logic        aes_valid,
  output logic        aes_dec,
  output logic        aes_op_sb,
  output logic        aes_op_sbsr,
  output logic        aes_op_mix,
  output logic        aes_hi,
  output logic [31:0] aes_rs1,
  output logic [31:0] aes_rs2,
  input  logic        aes_ready,
  input  logic [31:0] aes_rd
);

  aes_state_e  state_q, state_d;
  aes_op_e     op_q, op_d;
  logic        dec_q, dec_d;
  logic        hi_q, hi_d;
  logic        owner_q, owner_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] res_q, res_d;

  logic [1:0]  gnt;
  logic [1:0]  sel_op;
  logic        sel_dec, sel_hi, owner_rsp_ready;
  logic [31:0] sel_rs1, sel_rs2;

  aes_rr_arb2 u_arb (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid ({req1_valid, req0_valid}),
    .en        (g_resetn && (state_q == StIdle)),
    .gnt       (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_op  = gnt[1] ? req1_op  : req0_op;
  assign sel_dec = gnt[1] ? req1_dec : req0_dec;
  assign sel_hi  = gnt[1] ? req1_hi  : req0_hi;
  assign sel_rs1 = gnt[1] ? req1_rs1 : req0_rs1;
  assign sel_rs2 = gnt[1] ? req1_rs2 : req0_rs2;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dec_d   = dec_q;
    hi_d    = hi_q;
    owner_d = owner_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          op_d    = aes_op_e'(sel_op);
          dec_d   = sel_dec & DECRYPT_EN;
          hi_d    = sel_hi;
          rs1_d   = sel_rs1;
          rs2_d   = sel_rs2;
          owner_d = gnt[1];
          // Illegal ops bypass the unit and answer with zero.
          if (aes_op_e'(sel_op) == OpIllegal) begin
            res_d   = '0;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (aes_ready) begin
          res_d   = aes_rd;
          state_d = StResp;
        end
      end
      StResp: begin
        if (owner_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      op_q    <= OpSb;
      dec_q   <= 1'b0;
      hi_q    <= 1'b0;
      owner_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dec_q   <= dec_d;
      hi_q    <= hi_d;
      owner_q <= owner_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
    end
  end

  assign aes_valid   = g_resetn && (state_q == StIssue);
  assign aes_dec     = dec_q;
  assign aes_hi      = hi_q;
  assign aes_op_sb   = (op_q == OpSb);
  assign aes_op_sbsr = (op_q == OpSbsr);
  assign aes_op_mix  = (op_q == OpMix);
  assign aes_rs1     = rs1_q;
  assign aes_rs2     = rs2_q;

  assign rsp0_valid = g_resetn && (state_q == StResp) && !owner_q;
  assign rsp1_valid = g_resetn && (state_q == StResp) && owner_q;
  assign rsp0_rd    = res_q;
  assign rsp1_rd    = res_q;

endmodule

// File: tb/tb_aes_tiled_arb.sv
// Scoreboard bench for aes_tiled_arb with a 4-cycle behavioural AES unit model.
module tb_aes_tiled_arb;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;

  logic [1:0]       req_valid, req_ready, req_dec, req_hi, rsp_valid, rsp_ready;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_rs1, req_rs2, rsp_rd;
  logic             aes_valid, aes_dec, aes_op_sb, aes_op_sbsr, aes_op_mix, aes_hi;
  logic             aes_ready;
  logic [31:0]      aes_rs1, aes_rs2, aes_rd;

  // Second instance with decrypt disabled, run in lockstep on the same stimulus.
  logic [1:0]       nd_req_ready, nd_rsp_valid;
  logic [1:0][31:0] nd_rsp_rd;
  logic             nd_aes_valid, nd_aes_dec, nd_aes_op_sb, nd_aes_op_sbsr, nd_aes_op_mix;
  logic             nd_aes_hi;
  logic [31:0]      nd_aes_rs1, nd_aes_rs2;

  always #5 g_clk = ~g_clk;

  aes_tiled_arb #(.DECRYPT_EN(1'b1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_dec(req_dec[0]), .req0_hi(req_hi[0]), .req0_rs1(req_rs1[0]), .req0_rs2(req_rs2[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rd(rsp_rd[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_dec(req_dec[1]), .req1_hi(req_hi[1]), .req1_rs1(req_rs1[1]), .req1_rs2(req_rs2[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rd(rsp_rd[1]),
    .aes_valid(aes_valid), .aes_dec(aes_dec), .aes_op_sb(aes_op_sb),
    .aes_op_sbsr(aes_op_sbsr), .aes_op_mix(aes_op_mix), .aes_hi(aes_hi),
    .aes_rs1(aes_rs1), .aes_rs2(aes_rs2), .aes_ready(aes_ready), .aes_rd(aes_rd)
  );

  aes_tiled_arb #(.DECRYPT_EN(1'b0)) dut_nd (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req_valid[0]), .req0_ready(nd_req_ready[0]), .req0_op(req_op[0]),
    .req0_dec(req_dec[0]), .req0_hi(req_hi[0]), .req0_rs1(req_rs1[0]), .req0_rs2(req_rs2[0]),
    .rsp0_valid(nd_rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rd(nd_rsp_rd[0]),
    .req1_valid(req_valid[1]), .req1_ready(nd_req_ready[1]), .req1_op(req_op[1]),
    .req1_dec(req_dec[1]), .req1_hi(req_hi[1]), .req1_rs1(req_rs1[1]), .req1_rs2(req_rs2[1]),
    .rsp1_valid(nd_rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rd(nd_rsp_rd[1]),
    .aes_valid(nd_aes_valid), .aes_dec(nd_aes_dec), .aes_op_sb(nd_aes_op_sb),
    .aes_op_sbsr(nd_aes_op_sbsr), .aes_op_mix(nd_aes_op_mix), .aes_hi(nd_aes_hi),
    .aes_rs1(nd_aes_rs1), .aes_rs2(nd_aes_rs2), .aes_ready(aes_ready), .aes_rd(aes_rd)
  );

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  // Unit model: aes_ready three cycles after aes_valid; rd = rs1 ^ rs2 ^ control bits.
  int          ucnt = 0;
  logic        force_rdy = 1'b0;
  logic [31:0] lat_rs1, lat_rs2;
  logic [4:0]  lat_ctl, ctl;
  assign ctl = {aes_dec, aes_hi, aes_op_sb, aes_op_sbsr, aes_op_mix};

  always @(posedge g_clk) begin
    if (!g_resetn) begin
      ucnt <= 0;
    end else if (aes_valid) begin
      ucnt    <= 3;
      lat_rs1 <= aes_rs1;
      lat_rs2 <= aes_rs2;
      lat_ctl <= ctl;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
    end
  end

  assign aes_ready = (ucnt == 1) || force_rdy;
  assign aes_rd    = (ucnt == 1) ? (lat_rs1 ^ lat_rs2 ^ {27'b0, lat_ctl}) : 32'hdeadbeef;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  typedef struct { int owner; logic [31:0] rd; int due; } rsp_exp_t;
  typedef struct { int due; logic dec; logic [1:0] op; } aes_exp_t;

  rsp_exp_t sb_q[$];
  aes_exp_t aes_q[$];
  int       grant_log[$];
  int       hs_cyc[2];
  bit       seen[2];
  rsp_exp_t re;
  aes_exp_t ae;
  logic [2:0] oh;

  // Monitor: unit issue checks and response scoreboard.
  initial begin
    seen[0] = 0;
    seen[1] = 0;
    hs_cyc[0] = -1;
    hs_cyc[1] = -1;
    forever begin
      @(negedge g_clk);
      if (aes_valid) begin
        if (aes_q.size() == 0) begin
          check("aes_valid_unexpected", aes_valid, 0);
        end else begin
          ae = aes_q.pop_front();
          case (ae.op)
            2'b00:   oh = 3'b100;
            2'b01:   oh = 3'b010;
            default: oh = 3'b001;
          endcase
          check("aes_issue_cycle", cyc, ae.due);
          check("aes_dec", aes_dec, ae.dec);
          check("aes_op_onehot", {aes_op_sb, aes_op_sbsr, aes_op_mix}, oh);
          check("nd_aes_valid", nd_aes_valid, 1);
          check("nd_aes_dec_forced", nd_aes_dec, 0);
        end
      end
      if (ucnt == 1) begin
        check("aes_rs1_stable", aes_rs1, lat_rs1);
        check("aes_rs2_stable", aes_rs2, lat_rs2);
        check("aes_ctl_stable", ctl, lat_ctl);
      end
      for (int n = 0; n < 2; n++) begin
        if (rsp_valid[n]) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", rsp_valid[n], 0);
          end else begin
            re = sb_q[0];
            check("rsp_owner", n, re.owner);
            check("rsp_rd", rsp_rd[n], re.rd);
            if (!seen[n]) check("rsp_latency", cyc, re.due);
            seen[n] = 1;
            if (rsp_ready[n]) begin
              void'(sb_q.pop_front());
              seen[n] = 0;
              hs_cyc[n] = cyc;
            end
          end
        end else if (seen[n]) begin
          check("rsp_dropped", rsp_valid[n], 1);
          seen[n] = 0;
        end
      end
    end
  end

  task automatic issue(input int n, input logic [1:0] op, input logic dec, input logic hi,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] exp_rd, input bit exp_rsp,
                       output int waited, output int acc);
    rsp_exp_t r;
    aes_exp_t a;
    req_op[n]    = op;
    req_dec[n]   = dec;
    req_hi[n]    = hi;
    req_rs1[n]   = rs1;
    req_rs2[n]   = rs2;
    req_valid[n] = 1'b1;
    waited = 0;
    acc = -1;
    forever begin
      @(negedge g_clk);
      if (req_ready[n] || waited > 100) break;
      waited++;
    end
    if (!req_ready[n]) begin
      check("req_accept_timeout", req_ready[n], 1);
    end else begin
      acc = cyc;
      grant_log.push_back(n);
      if (exp_rsp) begin
        r.owner = n;
        r.rd    = exp_rd;
        r.due   = acc + ((op == 2'b11) ? 1 : 5);
        sb_q.push_back(r);
      end
      if (op != 2'b11) begin
        a.due = acc + 1;
        a.dec = dec;
        a.op  = op;
        aes_q.push_back(a);
      end
    end
    @(posedge g_clk);
    #1;
    // Operands are garbled after the handshake; the DUT must have registered them.
    req_valid[n] = 1'b0;
    req_rs1[n]   = ~rs1;
    req_rs2[n]   = ~rs2;
    req_op[n]    = ~op;
  endtask

  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    int w0, w1, a0, a1;
    req_valid = 2'b11;
    req_op    = '0;
    req_dec   = '0;
    req_hi    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    rsp_ready = 2'b11;
    g_resetn  = 1'b0;

    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_aes_valid", aes_valid, 0);
    @(posedge g_clk);
    #1;
    g_resetn  = 1'b1;
    req_valid = 2'b00;

    // Contention from reset: both requesters held busy, grants alternate starting at 0.
    fork
      begin
        issue(0, 2'b01, 1'b0, 1'b0, 32'h03020100, 32'h07060504, 32'h04040406, 1, w0, a0);
        issue(0, 2'b00, 1'b1, 1'b1, 32'hffff0000, 32'h0000ffff, 32'hffffffe3, 1, w0, a0);
      end
      begin
        issue(1, 2'b10, 1'b0, 1'b1, 32'h12345678, 32'h00000000, 32'h12345671, 1, w1, a1);
        issue(1, 2'b01, 1'b1, 1'b0, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffed, 1, w1, a1);
      end
    join
    check("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check("grant_order", grant_log[i], exp_order[i]);
    end
    repeat (6) @(posedge g_clk);
    #1;

    // Illegal op on req1 with its response back-pressured while req0 waits.
    rsp_ready[1] = 1'b0;
    issue(1, 2'b11, 1'b1, 1'b1, 32'hffffffff, 32'hffffffff, 32'h00000000, 1, w1, a1);
    fork
      issue(0, 2'b10, 1'b0, 1'b0, 32'h0f0f0f0f, 32'h00ff00ff, 32'h0ff00ff1, 1, w0, a0);
      begin
        repeat (10) @(posedge g_clk);
        #1;
        rsp_ready[1] = 1'b1;
      end
    join
    check("bp_accept_after_rsp", a0, hs_cyc[1] + 1);
    repeat (6) @(posedge g_clk);
    #1;

    // Reset while the unit is busy, then a stray aes_ready in IDLE.
    issue(0, 2'b01, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 0, w0, a0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    force_rdy = 1'b1;
    @(posedge g_clk);
    #1;
    force_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      check("abort_no_rsp0", rsp_valid[0], 0);
      check("abort_no_rsp1", rsp_valid[1], 0);
    end
    @(posedge g_clk);
    #1;

    // Single request after the abort: must be accepted at once from IDLE.
    issue(0, 2'b01, 1'b0, 1'b0, 32'h03020100, 32'h07060504, 32'h04040406, 1, w0, a0);
    check("idle_after_abort", w0, 0);
    repeat (8) @(posedge g_clk);
    #1;

    check("sb_drained", sb_q.size(), 0);
    check("aes_q_drained", aes_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_tiled_arb.md
AES_TILED_ARB -- requirements
Module: aes_tiled_arb

Interface
REQ-001 Parameter DECRYPT_EN, default 1, meaning: when 0, the dec bit of every request SHALL be forced to 0 before issue.
REQ-002 g_clk  input  1  clock; all state updates on rising edge.
REQ-003 g_resetn  input  1  reset; synchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an op pending.
REQ-005 reqN_ready  output  1  request N accepted this cycle when reqN_valid is also high.
REQ-006 reqN_op  input  2  operation code: 00 sb, 01 sbsr, 10 mix, 11 illegal.
REQ-007 reqN_dec / reqN_hi  input  1 each  decrypt select / high-half select.
REQ-008 reqN_rs1 / reqN_rs2  input  32 each  source operands.
REQ-009 rspN_valid  output  1  result pending for requester N.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rspN_rd  output  32  result data.
REQ-012 aes_valid  output  1  start pulse to the tiled AES unit.
REQ-013 aes_dec, aes_op_sb, aes_op_sbsr, aes_op_mix, aes_hi  output  1 each  unit controls.
REQ-014 aes_rs1 / aes_rs2  output  32 each  unit operands.
REQ-015 aes_ready  input  1  unit result strobe; aes_rd is valid only in this cycle.
REQ-016 aes_rd  input  32  unit result.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE->ISSUE on a request handshake with a legal op.
- IDLE->RESP on a handshake with op 11.
- ISSUE->WAIT unconditionally.
- WAIT->RESP on aes_ready.
- RESP->IDLE on the owner's rsp handshake.
REQ-018 reqN_ready SHALL be high only in IDLE and only for the requester granted this cycle; it is combinational from the valids and the RR pointer.
REQ-019 Arbitration:
- One valid requester: that requester is granted.
- Both valid: the requester not most recently granted is granted.
- RR pointer updates only on a grant handshake; reset value 0, so requester 0 wins the first tie.
REQ-020 On handshake, the block SHALL register op, dec (ANDed with DECRYPT_EN), hi, rs1, rs2 and the owner ID. The requester may change or drop its inputs the next cycle.
REQ-021 aes_rs1, aes_rs2 and all aes_op_* / aes_hi / aes_dec outputs SHALL be driven from these registers. They are stable from ISSUE through the aes_ready cycle inclusive.
REQ-022 aes_op_* SHALL be one-hot from the registered op.
REQ-023 aes_valid SHALL be high for exactly one cycle, in ISSUE.
REQ-024 In WAIT, aes_rd SHALL be captured into a 32-bit result register in the cycle aes_ready is high.
REQ-025 aes_ready outside WAIT SHALL be ignored.
REQ-026 For op 11, the unit SHALL NOT be issued and the result register SHALL be loaded with 0.
REQ-027 In RESP, rspN_valid SHALL be high only for the owner. rspN_rd SHALL equal the result register and hold stable until rspN_ready.
REQ-028 The non-owner's rsp_valid SHALL be 0. rspN_rd of the non-owner is don't-care; it is driven with the result register.
REQ-029 No request SHALL be accepted in the RESP cycle. The earliest next accept is the cycle after the rsp handshake.
REQ-030 Latency with the unit's 4-cycle sequence (aes_ready 3 cycles after aes_valid), counted from the accept cycle C:
- ISSUE C+1, aes_ready C+4, rsp_valid C+5.
- Illegal op: rsp_valid C+1.
REQ-031 Single outstanding op; peak throughput is one op per 6 cycles with rsp_ready held high.

Reset
REQ-032 While g_resetn is low at a clock edge: FSM to IDLE, RR pointer to 0, result register to 0, owner to 0.
REQ-033 Reset-time output values: all reqN_ready=0 during reset, rspN_valid=0, aes_valid=0.
REQ-034 Reset asserted mid-operation SHALL abandon the op without any response. The tiled unit shares g_resetn.

Structure
REQ-035 A shared package aes_tiled_pkg SHALL hold the op encoding constants (SB, SBSR, MIX, ILLEGAL) and the FSM state encodings.
REQ-036 A sub-module aes_rr_arb2 SHALL hold the 2-way round-robin grant logic and pointer. The top level holds the FSM, operand/result registers and unit drive.

Verification
REQ-037 Single request:
- Stimulus: req0 sbsr, rs1=0x03020100, rs2=0x07060504, hi=0.
- Response: one aes_valid at C+1, operands stable to aes_ready; rsp0_valid at C+5 with rd equal to aes_rd in the aes_ready cycle.
REQ-038 Contention:
- Stimulus: req0 and req1 valid together from reset.
- Response: req0 served first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-039 Backpressure:
- Stimulus: rsp1_ready held low 10 cycles with req0 pending.
- Response: rsp1_valid/rd stable; req0_ready stays 0 until the cycle after rsp1 handshake.
REQ-040 Illegal op:
- Stimulus: req1 op=11.
- Response: aes_valid never asserts; rsp1_valid at C+1 with rd=0x00000000.
REQ-041 DECRYPT_EN=0:
- Stimulus: req0 sbsr with dec=1.
- Response: aes_dec=0.
REQ-042 Reset mid-op:
- Stimulus: reset in WAIT, then a spurious aes_ready in IDLE.
- Response: no rsp_valid for either requester; state stays IDLE.
